my_uart_rx: RTL and testbench

//   UART receiver: 8N1, LSB first, idle-high serial line. Frame timing uses a baud

---
 rtl/my_uart_rx_pkg.sv | 16 +
 rtl/my_uart_rx_if.sv | 24 ++
 rtl/uart_sync2.sv | 25 ++
 rtl/my_uart_rx.sv | 127 ++++++++++++
 tb/tb_my_uart_rx.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/my_uart_rx_pkg.sv
// my_uart_rx shared definitions
// state encoding and default line settings
package my_uart_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   localparam int DEF_CLK_FREQ  = 125_000_000;
   localparam int DEF_BAUD_RATE = 115_200;

endpackage

// File: rtl/my_uart_rx_if.sv
// my_uart_rx user-side bundle
// receiver drives, user logic listens
interface my_uart_rx_if;

   logic [7:0] Data;
   logic       Valid;
   logic       Frame_err;
   logic       Busy;

   modport master (
      output Data,
      output Valid,
      output Frame_err,
      output Busy
   );

   modport slave (
      input Data,
      input Valid,
      input Frame_err,
      input Busy
   );

endinterface

// File: rtl/uart_sync2.sv
// uart_sync2: generic 2-FF synchronizer
// reset value selectable so an idle line reads idle
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // two flops in series; both preset to the idle level
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/my_uart_rx.sv
// my_uart_rx: 8N1 UART receiver, LSB first
// mid-bit sampling, counter reloads at each sample point
module my_uart_rx
   import my_uart_rx_pkg::*;
#(
   parameter int CLK_FREQ  = DEF_CLK_FREQ,
   parameter int BAUD_RATE = DEF_BAUD_RATE
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         Din,
   my_uart_rx_if.master rx
);

   localparam int BIT_CNT  = CLK_FREQ / BAUD_RATE;
   localparam int HALF_CNT = BIT_CNT / 2;
   localparam int CW       = $clog2(BIT_CNT);

   localparam logic [CW-1:0] HALF_END = CW'(HALF_CNT - 1);
   localparam logic [CW-1:0] BIT_END  = CW'(BIT_CNT - 1);

   state_t        state;
   state_t        nstate;
   logic          rx_s;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shift;
   logic [7:0]    data_q;
   logic          valid_q;
   logic          ferr_q;
   logic          busy;
   logic          tick_half;
   logic          tick_bit;

   uart_sync2 #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk (CLK),
      .rst (RST),
      .d   (Din),
      .q   (rx_s)
   );

   // state register
   always_ff @(posedge CLK) begin
      if (RST) state <= ST_IDLE;
      else     state <= nstate;
   end

   // next-state decode
   always_comb begin
      nstate = state;
      unique case (state)
         ST_IDLE:  if (!rx_s) nstate = ST_START;
         ST_START: if (tick_half)
                      nstate = rx_s ? ST_IDLE : ST_DATA;
         ST_DATA:  if (tick_bit && idx == 3'd7)
                      nstate = ST_STOP;
         ST_STOP:  if (tick_bit)
                      nstate = rx_s ? ST_IDLE : ST_BREAK;
         ST_BREAK: if (rx_s) nstate = ST_IDLE;
         default:  nstate = ST_IDLE;
      endcase
   end

   // state-derived outputs and sample strobes
   always_comb begin
      busy      = (state != ST_IDLE);
      tick_half = (cnt == HALF_END);
      tick_bit  = (cnt == BIT_END);
   end

   // baud counter, bit index, shift register, output pulses
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt     <= '0;
         idx     <= '0;
         shift   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               cnt <= '0;
               idx <= '0;
            end
            ST_START: begin
               if (tick_half) cnt <= '0;
               else           cnt <= cnt + 1'b1;
            end
            ST_DATA: begin
               if (tick_bit) begin
                  cnt        <= '0;
                  shift[idx] <= rx_s;
                  idx        <= idx + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (tick_bit) begin
                  cnt <= '0;
                  if (rx_s) begin
                     data_q  <= shift;
                     valid_q <= 1'b1;
                  end else begin
                     ferr_q <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_BREAK: cnt <= '0;
            default:  cnt <= '0;
         endcase
      end
   end

   assign rx.Data      = data_q;
   assign rx.Valid     = valid_q;
   assign rx.Frame_err = ferr_q;
   assign rx.Busy      = busy;

endmodule

// File: tb/tb_my_uart_rx.sv
// tb_my_uart_rx: directed bench for my_uart_rx
// 10 CLK per bit, hand-computed expectations
`timescale 1ns/1ps
module tb_my_uart_rx;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic din_drv = 1'b1;
   logic use_tx = 1'b0;
   logic Din;

   int n_chk = 0;
   int n_err = 0;

   int n_valid = 0;
   int n_ferr = 0;
   int n_both = 0;
   int n_busy_bad = 0;
   logic [7:0] got_q[$];

   logic       tx_go = 1'b0;
   logic [7:0] tx_byte = 8'h00;
   logic [9:0] tx_sh = 10'h3ff;
   logic       tx_busy = 1'b0;
   int         tx_cnt = 0;
   int         tx_bits = 0;
   logic       tx_line;

   my_uart_rx_if rx_if ();

   my_uart_rx #(
      .CLK_FREQ  (1_152_000),
      .BAUD_RATE (115_200)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .Din (Din),
      .rx  (rx_if)
   );

   always #434 CLK = ~CLK;

   assign tx_line = tx_busy ? tx_sh[0] : 1'b1;
   assign Din = use_tx ? tx_line : din_drv;

   // reference transmitter: start, 8 data LSB first, stop
   always @(posedge CLK) begin
      if (tx_go && !tx_busy) begin
         tx_sh   <= {1'b1, tx_byte, 1'b0};
         tx_busy <= 1'b1;
         tx_cnt  <= 0;
         tx_bits <= 0;
      end else if (tx_busy) begin
         if (tx_cnt == 9) begin
            tx_cnt  <= 0;
            tx_sh   <= {1'b1, tx_sh[9:1]};
            tx_bits <= tx_bits + 1;
            if (tx_bits == 9) tx_busy <= 1'b0;
         end else begin
            tx_cnt <= tx_cnt + 1;
         end
      end
   end

   // output monitor on the falling edge
   always @(negedge CLK) begin
      if (rx_if.Valid) begin
         got_q.push_back(rx_if.Data);
         n_valid++;
         if (rx_if.Busy) n_busy_bad++;
      end
      if (rx_if.Frame_err) n_ferr++;
      if (rx_if.Valid && rx_if.Frame_err) n_both++;
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic bit_out(input logic v);
      din_drv = v;
      clks(10);
   endtask

   task automatic data_stop(input logic [7:0] b,
                            input logic stp);
      for (int i = 0; i < 8; i++) bit_out(b[i]);
      bit_out(stp);
   endtask

   task automatic send(input logic [7:0] b);
      bit_out(1'b0);
      data_stop(b, 1'b1);
   endtask

   task automatic tx_send(input logic [7:0] b);
      int t;
      tx_byte = b;
      tx_go = 1'b1;
      clks(1);
      tx_go = 1'b0;
      t = 0;
      while (tx_busy && t < 300) begin
         clks(1);
         t++;
      end
      check("tx_done", {31'd0, tx_busy}, 32'd0);
      clks(5);
   endtask

   initial begin
      int base_v;
      int base_f;
      int base_q;

      // 1: reset
      clks(3);
      check("rst_data", rx_if.Data, 32'h00);
      check("rst_valid", rx_if.Valid, 0);
      check("rst_ferr", rx_if.Frame_err, 0);
      check("rst_busy", rx_if.Busy, 0);
      clks(2);
      RST = 1'b0;
      clks(5);
      check("post_rst_busy", rx_if.Busy, 0);
      check("post_rst_data", rx_if.Data, 32'h00);
      check("post_rst_valid_cnt", n_valid, 0);

      // 2: 8'h55 with busy timing
      din_drv = 1'b0;
      clks(2);
      check("busy_early", rx_if.Busy, 0);
      clks(1);
      check("busy_rise", rx_if.Busy, 1);
      clks(7);
      data_stop(8'h55, 1'b1);
      clks(5);
      check("t2_nvalid", n_valid, 1);
      check("t2_data", rx_if.Data, 32'h55);
      check("t2_busy", rx_if.Busy, 0);

      // 3: back-to-back A3, 0F
      base_q = got_q.size();
      send(8'hA3);
      send(8'h0F);
      clks(5);
      check("t3_nvalid", n_valid, 3);
      check("t3_q_len", got_q.size(), base_q + 2);
      if (got_q.size() == base_q + 2) begin
         check("t3_first", got_q[base_q], 32'hA3);
         check("t3_second", got_q[base_q+1], 32'h0F);
      end
      check("t3_data", rx_if.Data, 32'h0F);
      check("t3_ferr", n_ferr, 0);

      // 4: 3-clock glitch
      din_drv = 1'b0;
      clks(3);
      din_drv = 1'b1;
      clks(1);
      check("t4_busy_pulse", rx_if.Busy, 1);
      clks(20);
      check("t4_busy_end", rx_if.Busy, 0);
      check("t4_nvalid", n_valid, 3);
      check("t4_data", rx_if.Data, 32'h0F);

      // 5: bad stop bit, held low, then recovery
      bit_out(1'b0);
      data_stop(8'h81, 1'b0);
      clks(30);
      check("t5_nferr", n_ferr, 1);
      check("t5_nvalid", n_valid, 3);
      check("t5_data", rx_if.Data, 32'h0F);
      check("t5_break_busy", rx_if.Busy, 1);
      din_drv = 1'b1;
      clks(5);
      check("t5_idle", rx_if.Busy, 0);
      send(8'h3C);
      clks(5);
      check("t5_nferr_once", n_ferr, 1);
      check("t5_recover", rx_if.Data, 32'h3C);
      check("t5_nvalid2", n_valid, 4);

      // 6: reset in the middle of 8'hFF
      base_v = n_valid;
      base_f = n_ferr;
      bit_out(1'b0);
      bit_out(1'b1);
      bit_out(1'b1);
      bit_out(1'b1);
      bit_out(1'b1);
      check("t6_busy_mid", rx_if.Busy, 1);
      RST = 1'b1;
      clks(1);
      RST = 1'b0;
      check("t6_busy_rst", rx_if.Busy, 0);
      check("t6_data_rst", rx_if.Data, 32'h00);
      clks(50);
      check("t6_nvalid", n_valid, base_v);
      check("t6_nferr", n_ferr, base_f);
      send(8'h12);
      clks(5);
      check("t6_recover", rx_if.Data, 32'h12);

      // 7: loopback from reference transmitter
      use_tx = 1'b1;
      tx_send(8'h01);
      check("t7_b01", rx_if.Data, 32'h01);
      tx_send(8'h02);
      check("t7_b02", rx_if.Data, 32'h02);
      check("t7_nvalid", n_valid, base_v + 3);

      // global properties
      check("never_both", n_both, 0);
      check("busy_in_valid", n_busy_bad, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
